fetch_request_unit: RTL
=======================

// Module: fetch_request_unit
// PURPOSE
// - Sequencer between the PC block and the memory arbiter.
// - Reads pc_addr and fetches the instruction via the imem handshake.
// - Holds the instruction for the datapath and services at most one dmem access per instruction.
// - Issues the one-cycle pcenable that advances the PC.
// - Sits between pc, control/datapath and the cache/arbiter ports.
// PARAMETERS
// - ADDR_W    32  address width
// - DATA_W    32  instruction/data word width
// - MAX_WAIT  16  wait cycles in FETCH/MEM before the sticky timeout flag sets
// PORTS
// - CLK          in   1       clock, rising edge
// - nRST         in   1       reset; asynchronous, active-low
// - pc_addr      in   ADDR_W  current PC (ladd from pc)
// - pcenable     out  1       advance PC this cycle
// - halt         in   1       decoded halt of the held instruction
// - mem_ren      in   1       held instruction is a load
// - mem_wen      in   1       held instruction is a store
// - mem_addr     in   ADDR_W  effective address from ALU
// - mem_store    in   DATA_W  store data
// - imemREN      out  1       instruction read request
// - imemaddr     out  ADDR_W  instruction address
// - ihit         in   1       instruction read complete
// - imemload     in   DATA_W  instruction read data
// - dmemREN      out  1       data read request
// - dmemWEN      out  1       data write request
// - dmemaddr     out  ADDR_W  data address
// - dmemstore    out  DATA_W  data write value
// - dhit         in   1       data access complete
// - dmemload     in   DATA_W  data read value
// - instr        out  DATA_W  held instruction
// - instr_valid  out  1       instr valid for the datapath
// - dload        out  DATA_W  registered load result
// - halted       out  1       sticky halt
// - timeout      out  1       sticky: wait count exceeded MAX_WAIT
// - proto_err    out  1       sticky: mem_ren and mem_wen asserted together
// - instr_count  out  32      retired-instruction counter
// BEHAVIOUR
// - Reset values:
//   - all outputs 0; state RESET.
//   - Reset is asynchronous, so asserting nRST mid-operation drops imemREN, dmemREN and dmemWEN immediately.
//   - Any in-flight access is abandoned.
// - States: RESET, FETCH, EXEC, MEM, HALTED.
// - RESET -> FETCH unconditionally on the first clock edge.
// - FETCH:
//   - imemREN=1 and imemaddr=pc_addr, both combinational.
//   - On ihit: instr<=imemload, instr_valid<=1 at the edge, then -> EXEC.
//   - Fetch latency = ihit latency + 1 cycle.
// - EXEC: instr_valid=1; mem_ren, mem_wen and halt are sampled this cycle. Priority:
//   1. halt -> HALTED; no pcenable.
//   2. mem_ren|mem_wen -> MEM; latch dmemaddr, dmemstore and the request type.
//   3. otherwise pcenable=1 (combinational), -> FETCH, instr_valid<=0.
// - MEM:
//   - dmemREN or dmemWEN is driven from the latched type; instr_valid stays 1.
//   - On dhit: pcenable=1, dload<=dmemload (reads only), -> FETCH, instr_valid<=0.
// - Simultaneous mem_ren and mem_wen in EXEC: treated as a write only, and proto_err<=1.
// - pcenable:
//   - exactly one cycle per retired instruction; never asserted in FETCH, RESET or HALTED.
//   - The PC updates on the same edge, so the next FETCH uses the new pc_addr.
// - ihit/dhit arriving outside their own request state are ignored, and so is a stray hit during the other request.
// - HALTED:
//   - absorbing until reset; halted=1; no memory requests.
//   - instr_valid held 1 so the datapath can flush.
// - Wait counter:
//   - clears on entry to FETCH or MEM; increments each cycle without a hit there; saturates at MAX_WAIT.
//   - timeout<=1 when it reaches MAX_WAIT. The access is not aborted.
// - instr_count increments on every pcenable and wraps 2^32-1 -> 0.
// STRUCTURE
// - cpu_types_pkg: word_t, fetch_state_t enum (RESET, FETCH, EXEC, MEM, HALTED).
// - One sub-module: req_wait_counter (clear, inc, saturate at MAX_WAIT, sat flag).
// - Everything else is inline: state register, outputs decoded combinationally from the state.
// TESTING
// - Reset released, pc_addr=0, ihit after 2 cycles, instr ADD -> imemREN 2 cycles, then EXEC with pcenable 1 cycle; instr_count=1.
// - Load: mem_ren=1, mem_addr=0x100, dhit after 3 cycles, dmemload=0xDEADBEEF -> dmemREN 3 cycles; dload=0xDEADBEEF; single pcenable on the dhit cycle.
// - Store: mem_wen=1, mem_store=0x1234 -> dmemWEN with dmemstore=0x1234. Both ren and wen asserted -> write only, proto_err=1.
// - Halt in EXEC -> HALTED; pcenable never asserted; no further imemREN over 20 cycles; halted=1.
// - ihit withheld 20 cycles (MAX_WAIT=16) -> timeout=1 at cycle 16; a later ihit still completes the fetch.
// - nRST pulsed low mid-MEM -> dmemREN=0 immediately; all outputs 0; FETCH resumes after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch request unit: word type, sequencer states and dmem request kind.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    RESET,
    FETCH,
    EXEC,
    MEM,
    HALTED
  } fetch_state_t;

  typedef enum logic {
    REQ_READ,
    REQ_WRITE
  } mem_req_t;

endpackage

// File: rtl/fetch_request_unit_if.sv
// Instruction and data memory handshake between the fetch request unit and the cache/arbiter.
interface fetch_request_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              ihit;
  logic [DATA_W-1:0] imemload;

  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ihit, imemload, dhit, dmemload
  );

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ihit, imemload, dhit, dmemload
  );

endinterface

// File: rtl/fetch_request_unit_req_wait_counter.sv
// Saturating wait-cycle counter for an outstanding memory request.
module req_wait_counter #(
  parameter int MAX_WAIT = 16,
  parameter int CW       = $clog2(MAX_WAIT + 1)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic inc,
  output logic sat,
  output logic reach
);

  logic [CW-1:0] count;

  assign sat   = (count == CW'(MAX_WAIT));
  // High on the cycle whose increment lands exactly on MAX_WAIT.
  assign reach = inc && !clear && (count == CW'(MAX_WAIT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_request_unit.sv
// Sequencer between PC, datapath and the memory arbiter: fetch, at most one dmem access, retire.
module fetch_request_unit
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [ADDR_W-1:0]   pc_addr,
  output logic                pcenable,
  input  logic                halt,
  input  logic                mem_ren,
  input  logic                mem_wen,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_store,
  fetch_request_unit_if.master mem,
  output logic [DATA_W-1:0]   instr,
  output logic                instr_valid,
  output logic [DATA_W-1:0]   dload,
  output logic                halted,
  output logic                timeout,
  output logic                proto_err,
  output word_t               instr_count
);

  fetch_state_t      state;
  mem_req_t          req_type;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic [DATA_W-1:0] dmem_store_q;

  logic mem_done;
  logic exec_retire;
  logic wait_inc;
  logic wait_sat;
  logic wait_reach;

  // NOTE: requests are decoded from the state register, so the asynchronous reset drops them at once.
  assign mem.imemREN   = (state == FETCH);
  assign mem.imemaddr  = (state == FETCH) ? pc_addr : '0;
  assign mem.dmemREN   = (state == MEM) && (req_type == REQ_READ);
  assign mem.dmemWEN   = (state == MEM) && (req_type == REQ_WRITE);
  assign mem.dmemaddr  = dmem_addr_q;
  assign mem.dmemstore = dmem_store_q;

  assign instr_valid = (state == EXEC) || (state == MEM) || (state == HALTED);
  assign halted      = (state == HALTED);

  assign mem_done    = (state == MEM) && mem.dhit;
  assign exec_retire = (state == EXEC) && !halt && !(mem_ren || mem_wen);
  assign pcenable    = exec_retire || mem_done;

  // Hits are only honoured by the state that issued the matching request.
  assign wait_inc = ((state == FETCH) && !mem.ihit) || ((state == MEM) && !mem.dhit);

  req_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .CLK   (CLK),
    .nRST  (nRST),
    .clear (!wait_inc),
    .inc   (wait_inc),
    .sat   (wait_sat),
    .reach (wait_reach)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= RESET;
      req_type     <= REQ_READ;
      dmem_addr_q  <= '0;
      dmem_store_q <= '0;
      instr        <= '0;
      dload        <= '0;
      timeout      <= 1'b0;
      proto_err    <= 1'b0;
      instr_count  <= '0;
    end else begin
      case (state)
        RESET: state <= FETCH;
        FETCH: begin
          if (mem.ihit) begin
            instr <= mem.imemload;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (halt) begin
            state <= HALTED;
          end else if (mem_ren || mem_wen) begin
            state        <= MEM;
            dmem_addr_q  <= mem_addr;
            dmem_store_q <= mem_store;
            // A conflicting load+store request is serviced as a store and flagged.
            req_type     <= mem_wen ? REQ_WRITE : REQ_READ;
            if (mem_ren && mem_wen) proto_err <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        MEM: begin
          if (mem.dhit) begin
            if (req_type == REQ_READ) dload <= mem.dmemload;
            state <= FETCH;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= RESET;
      endcase

      if (pcenable) instr_count <= instr_count + 1'b1;
      if (wait_reach || wait_sat) timeout <= 1'b1;
    end
  end

endmodule
